// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: byte buffering between the bus and a UART core.
// Two independent show-ahead FIFOs, a TX launch FSM, and RX overflow/error status.

module uart_fifo_bridge_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok, pop_ok;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    pop_ok   = pop && (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    push_ok  = push && ((level_q != LVL_FULL) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define validity,
  // which keeps this a plain RAM array.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

endmodule

module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  rx_overflow,
  input  logic                  clear_overflow,
  output logic [7:0]            rx_error_count,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting,
  input  logic                  uart_received,
  input  logic [7:0]            uart_rx_byte,
  input  logic                  uart_recv_error
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_e;

  tx_state_e  tx_state_q, tx_state_d;
  logic       uart_transmit_q, uart_transmit_d;
  logic [7:0] uart_tx_byte_q, uart_tx_byte_d;
  logic       rx_overflow_q, rx_overflow_d;
  logic [7:0] rx_error_count_q, rx_error_count_d;

  logic [7:0] tx_head, rx_head;
  logic       tx_empty, tx_pop;
  logic       rx_full, rx_pop, rx_drop;

  uart_fifo_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  uart_fifo_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (uart_received),
    .push_data (uart_rx_byte),
    .pop       (rd_en),
    .head      (rx_head),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // One byte in flight: launch, then wait for the core to go busy and idle again.
  always_comb begin
    tx_state_d      = tx_state_q;
    tx_pop          = 1'b0;
    uart_transmit_d = 1'b0;
    uart_tx_byte_d  = uart_tx_byte_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !uart_is_transmitting) begin
          tx_pop          = 1'b1;
          uart_transmit_d = 1'b1;
          uart_tx_byte_d  = tx_head;
          tx_state_d      = TX_LAUNCH;
        end
      end
      TX_LAUNCH:    tx_state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (uart_is_transmitting)  tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_is_transmitting) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q      <= TX_IDLE;
      uart_transmit_q <= 1'b0;
      uart_tx_byte_q  <= '0;
    end else begin
      tx_state_q      <= tx_state_d;
      uart_transmit_q <= uart_transmit_d;
      uart_tx_byte_q  <= uart_tx_byte_d;
    end
  end

  // A received byte is lost only when the FIFO is full and no read frees a slot.
  always_comb begin
    rx_pop           = rd_en && !rx_empty;
    rx_drop          = uart_received && rx_full && !rx_pop;
    rx_overflow_d    = rx_overflow_q;
    rx_error_count_d = rx_error_count_q;
    if (rx_drop) begin
      rx_overflow_d = 1'b1;
    end else if (clear_overflow) begin
      rx_overflow_d = 1'b0;
    end
    if (uart_recv_error && (rx_error_count_q != 8'hFF)) begin
      rx_error_count_d = rx_error_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow_q    <= 1'b0;
      rx_error_count_q <= '0;
    end else begin
      rx_overflow_q    <= rx_overflow_d;
      rx_error_count_q <= rx_error_count_d;
    end
  end

  assign rd_data        = rx_empty ? 8'h00 : rx_head;
  assign rx_overflow    = rx_overflow_q;
  assign rx_error_count = rx_error_count_q;
  assign uart_transmit  = uart_transmit_q;
  assign uart_tx_byte   = uart_tx_byte_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Testbench for uart_fifo_bridge: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model and a reactive UART core.

module tb_uart_fifo_bridge;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_en = 1'b0;
  logic [7:0]          wr_data = '0;
  logic                rd_en = 1'b0;
  logic                clear_overflow = 1'b0;
  logic                uart_received = 1'b0;
  logic [7:0]          uart_rx_byte = '0;
  logic                uart_recv_error = 1'b0;
  logic                core_busy = 1'b0;
  logic                hold_busy = 1'b0;
  logic                uart_is_transmitting;

  logic                tx_full, rx_empty, rx_overflow, uart_transmit;
  logic [DEPTH_LOG2:0] tx_level, rx_level;
  logic [7:0]          rd_data, rx_error_count, uart_tx_byte;

  assign uart_is_transmitting = core_busy | hold_busy;

  uart_fifo_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .tx_full              (tx_full),
    .tx_level             (tx_level),
    .rd_en                (rd_en),
    .rd_data              (rd_data),
    .rx_empty             (rx_empty),
    .rx_level             (rx_level),
    .rx_overflow          (rx_overflow),
    .clear_overflow       (clear_overflow),
    .rx_error_count       (rx_error_count),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .uart_received        (uart_received),
    .uart_rx_byte         (uart_rx_byte),
    .uart_recv_error      (uart_recv_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: byte queues plus "one byte in flight until the core was busy then idle".
  logic [7:0] q_tx[$];
  logic [7:0] q_rx[$];
  logic       m_ovf = 1'b0;
  int         m_err = 0;
  logic       m_in_flight = 1'b0;
  logic       m_seen_rise = 1'b0;
  logic       m_strobe = 1'b0;
  logic [7:0] m_tx_byte = '0;
  logic       rst_seen = 1'b0;

  // Reactive UART core and launch bookkeeping.
  logic       core_pend = 1'b0;
  int         core_dly = 0, core_dur = 0, core_left = 0;
  logic       core_long = 1'b0;
  logic       seen_hi = 1'b0, cyc_done = 1'b1;
  int         n_launch = 0;
  logic [7:0] got_q[$];

  task automatic model_edge();
    logic rx_fits;
    rst_seen = rst;
    if (rst) begin
      q_tx.delete();
      q_rx.delete();
      m_ovf = 1'b0; m_err = 0; m_in_flight = 1'b0; m_seen_rise = 1'b0;
      m_strobe = 1'b0; m_tx_byte = '0;
      return;
    end
    m_strobe = 1'b0;
    if (!m_in_flight) begin
      if (q_tx.size() != 0 && !uart_is_transmitting) begin
        m_tx_byte   = q_tx.pop_front();
        m_strobe    = 1'b1;
        m_in_flight = 1'b1;
        m_seen_rise = 1'b0;
      end
    end else if (!m_seen_rise) begin
      m_seen_rise = uart_is_transmitting;
    end else if (!uart_is_transmitting) begin
      m_in_flight = 1'b0;
    end
    if (wr_en && q_tx.size() < DEPTH) q_tx.push_back(wr_data);
    if (rd_en && q_rx.size() != 0) void'(q_rx.pop_front());
    rx_fits = (q_rx.size() < DEPTH);
    if (uart_received && rx_fits) q_rx.push_back(uart_rx_byte);
    if (uart_received && !rx_fits) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    if (uart_recv_error && m_err < 255) m_err++;
  endtask

  task automatic core_update();
    if (rst_seen) begin
      core_pend = 1'b0; core_left = 0; core_busy = 1'b0;
      seen_hi = 1'b0; cyc_done = 1'b1;
      return;
    end
    if (uart_is_transmitting) seen_hi = 1'b1;
    else if (seen_hi) cyc_done = 1'b1;
    if (uart_transmit === 1'b1) begin
      n_launch++;
      got_q.push_back(uart_tx_byte);
      check("launch_after_busy_cycle", {31'd0, cyc_done}, 32'd1);
      cyc_done  = 1'b0;
      seen_hi   = 1'b0;
      core_pend = 1'b1;
      core_dly  = $urandom_range(0, 2);
      core_dur  = core_long ? 20 : $urandom_range(2, 5);
    end
    if (core_pend) begin
      if (core_dly == 0) begin
        core_pend = 1'b0;
        core_left = core_dur;
      end else begin
        core_dly--;
      end
    end
    core_busy = (core_left != 0);
    if (core_left != 0) core_left--;
  endtask

  task automatic compare_all();
    check("tx_level",       32'(tx_level),       32'(q_tx.size()));
    check("tx_full",        32'(tx_full),        32'(q_tx.size() == DEPTH));
    check("rx_level",       32'(rx_level),       32'(q_rx.size()));
    check("rx_empty",       32'(rx_empty),       32'(q_rx.size() == 0));
    check("rd_data",        32'(rd_data),        32'((q_rx.size() != 0) ? q_rx[0] : 8'h00));
    check("rx_overflow",    32'(rx_overflow),    32'(m_ovf));
    check("rx_error_count", 32'(rx_error_count), 32'(m_err));
    check("uart_transmit",  32'(uart_transmit),  32'(m_strobe));
    check("uart_tx_byte",   32'(uart_tx_byte),   32'(m_tx_byte));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    core_update();
    compare_all();
  endtask

  task automatic clear_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
    uart_received = 1'b0; uart_recv_error = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] fill[DEPTH];
    int launches_before;

    // 1: reset values, then a single write launches at the next edge
    rst = 1'b1;
    tick(); tick();
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full",  32'(tx_full),  32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    rst = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    check("t1_level_one", 32'(tx_level), 32'd1);
    check("t1_no_strobe_yet", 32'(uart_transmit), 32'd0);
    tick();
    check("t1_strobe",    32'(uart_transmit), 32'd1);
    check("t1_byte",      32'(uart_tx_byte),  32'h41);
    check("t1_level_zero", 32'(tx_level),     32'd0);
    tick();
    check("t1_strobe_one_cycle", 32'(uart_transmit), 32'd0);
    idle(12);

    // 2: fill TX while the core is busy; overflow write dropped; in-order drain
    hold_busy = 1'b1;
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    check("t2_full", 32'(tx_full), 32'd1);
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("t2_drop_level", 32'(tx_level), 32'd16);
    idle(3);
    hold_busy = 1'b0;
    idle(250);
    check("t2_launch_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < got_q.size() && i < DEPTH; i++) check("t2_order", 32'(got_q[i]), 32'(i));

    // 3: three received bytes, show-ahead reads, read on empty ignored
    uart_received = 1'b1; uart_rx_byte = 8'h10; tick();
    uart_rx_byte = 8'h20; tick();
    uart_rx_byte = 8'h30; tick();
    uart_received = 1'b0;
    check("t3_level", 32'(rx_level), 32'd3);
    check("t3_head",  32'(rd_data),  32'h10);
    rd_en = 1'b1;
    tick(); check("t3_second", 32'(rd_data), 32'h20);
    tick(); check("t3_third",  32'(rd_data), 32'h30);
    tick(); check("t3_empty",  32'(rx_empty), 32'd1);
    tick(); check("t3_extra_read", 32'(rx_level), 32'd0);
    rd_en = 1'b0;

    // 4: RX overflow, push+pop when full, clear and set/clear priority
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 8'($urandom_range(0, 255));
      if (fill[i] == 8'h99) fill[i] = 8'h98;
      uart_received = 1'b1; uart_rx_byte = fill[i];
      tick();
    end
    uart_rx_byte = 8'h99; tick();
    uart_received = 1'b0;
    check("t4_overflow", 32'(rx_overflow), 32'd1);
    check("t4_level_full", 32'(rx_level), 32'd16);
    check("t4_head_kept", 32'(rd_data), 32'(fill[0]));
    uart_received = 1'b1; uart_rx_byte = 8'h5A; rd_en = 1'b1;
    tick();
    clear_inputs();
    check("t4_full_push_pop", 32'(rx_level), 32'd16);
    check("t4_head_advanced", 32'(rd_data), 32'(fill[1]));
    clear_overflow = 1'b1; tick();
    check("t4_cleared", 32'(rx_overflow), 32'd0);
    uart_received = 1'b1; uart_rx_byte = 8'h77; tick();
    clear_inputs();
    check("t4_set_wins", 32'(rx_overflow), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t4_no_dropped_byte", 32'(rd_data == 8'h99), 32'd0);
      tick();
    end
    rd_en = 1'b0;
    check("t4_drained", 32'(rx_empty), 32'd1);

    // Randomized concurrent traffic on both paths
    for (int i = 0; i < 1500; i++) begin
      wr_en           = ($urandom_range(0, 99) < 30);
      wr_data         = 8'($urandom_range(0, 255));
      rd_en           = ($urandom_range(0, 99) < 30);
      uart_received   = ($urandom_range(0, 99) < 35);
      uart_rx_byte    = 8'($urandom_range(0, 255));
      uart_recv_error = ($urandom_range(0, 99) < 5);
      clear_overflow  = ($urandom_range(0, 99) < 5);
      tick();
    end
    idle(250);

    // 5: error counter saturates
    uart_recv_error = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    uart_recv_error = 1'b0;
    check("t5_saturated", 32'(rx_error_count), 32'd255);
    tick();

    // 6: reset while waiting for the core to finish, five bytes queued
    core_long = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    idle(6);
    check("t6_queued", 32'(tx_level), 32'd5);
    check("t6_core_busy", 32'(uart_is_transmitting), 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("t6_level_zero", 32'(tx_level), 32'd0);
    check("t6_no_strobe",  32'(uart_transmit), 32'd0);
    check("t6_err_zero",   32'(rx_error_count), 32'd0);
    launches_before = n_launch;
    idle(40);
    check("t6_no_launch_after_rst", 32'(n_launch - launches_before), 32'd0);
    wr_en = 1'b1; wr_data = 8'hC3; tick();
    wr_en = 1'b0; tick();
    check("t6_idle_relaunch", 32'(uart_transmit), 32'd1);
    check("t6_relaunch_byte", 32'(uart_tx_byte),  32'hC3);
    core_long = 1'b0;
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
